// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: load-path register address,
// key_data bit positions and the row-pattern decode helper.
package keypad_scanner_pkg;

    localparam logic [31:0] KEY_BASE_ADDR = 32'hFFFF_0100;
    localparam int          KEY_NEW_BIT   = 4;
    localparam int          KEY_HELD_BIT  = 5;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // A press is a single low row; anything else (none, ghosting) is rejected.
    function automatic row_hit_t decode_row(input logic [3:0] rows);
        row_hit_t hit;
        hit.valid = 1'b1;
        case (rows)
            4'b1110: hit.idx = 2'd0;
            4'b1101: hit.idx = 2'd1;
            4'b1011: hit.idx = 2'd2;
            4'b0111: hit.idx = 2'd3;
            default: begin
                hit.valid = 1'b0;
                hit.idx   = 2'd0;
            end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the active-low keypad rows; idles at all-high.
module row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] row_s
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two-stage capture of the asynchronous rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= row_in;
            sync_q <= meta_q;
        end
    end

    assign row_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and a read-clear key register
// presented to the load multiplexer.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        key_rd,
    output logic [31:0] key_data
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_new_q, key_new_d;
    logic          key_held_q, key_held_d;
    logic [3:0]    row_s;
    logic [3:0]    map_code_s;
    row_hit_t      hit_s;

    row_sync u_row_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_in (row_in),
        .row_s  (row_s)
    );

    // Key legend lookup for the latched row/column; '*' reads as E, '#' as F.
    always_comb begin
        case ({row_q, col_q})
            4'h0:    map_code_s = 4'h1;
            4'h1:    map_code_s = 4'h2;
            4'h2:    map_code_s = 4'h3;
            4'h3:    map_code_s = 4'hA;
            4'h4:    map_code_s = 4'h4;
            4'h5:    map_code_s = 4'h5;
            4'h6:    map_code_s = 4'h6;
            4'h7:    map_code_s = 4'hB;
            4'h8:    map_code_s = 4'h7;
            4'h9:    map_code_s = 4'h8;
            4'hA:    map_code_s = 4'h9;
            4'hB:    map_code_s = 4'hC;
            4'hC:    map_code_s = 4'hE;
            4'hD:    map_code_s = 4'h0;
            4'hE:    map_code_s = 4'hF;
            4'hF:    map_code_s = 4'hD;
            default: map_code_s = 4'h0;
        endcase
    end

    // Scan / debounce next-state logic; a press acceptance overrides a same-cycle read-clear.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        div_cnt_d  = div_cnt_q;
        db_cnt_d   = db_cnt_q;
        key_code_d = key_code_q;
        key_held_d = key_held_q;
        hit_s      = decode_row(row_s);
        if (key_rd) begin
            key_new_d = 1'b0;
        end else begin
            key_new_d = key_new_q;
        end

        case (state_q)
            ST_SCAN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = CNT_ZERO;
                    db_cnt_d  = CNT_ZERO;
                    if (hit_s.valid) begin
                        state_d = ST_PRESS_DB;
                        row_d   = hit_s.idx;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_ONE;
                end
            end
            ST_PRESS_DB: begin
                if (row_s == ~(4'b0001 << row_q)) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d    = ST_HELD;
                        db_cnt_d   = CNT_ZERO;
                        key_code_d = map_code_s;
                        key_new_d  = 1'b1;
                        key_held_d = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d   = ST_SCAN;
                    col_d     = col_q + 2'd1;
                    div_cnt_d = CNT_ZERO;
                    db_cnt_d  = CNT_ZERO;
                end
            end
            ST_HELD: begin
                if (row_s == 4'hF) begin
                    state_d  = ST_REL_DB;
                    db_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_REL_DB: begin
                if (row_s == 4'hF) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d    = ST_SCAN;
                        key_held_d = 1'b0;
                        col_d      = col_q + 2'd1;
                        div_cnt_d  = CNT_ZERO;
                        db_cnt_d   = CNT_ZERO;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = ST_HELD;
                    db_cnt_d = CNT_ZERO;
                end
            end
            default: begin
                state_d   = ST_SCAN;
                col_d     = 2'd0;
                div_cnt_d = CNT_ZERO;
                db_cnt_d  = CNT_ZERO;
            end
        endcase

        col_out_d = ~(4'b0001 << col_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            div_cnt_q  <= CNT_ZERO;
            db_cnt_q   <= CNT_ZERO;
            col_out_q  <= 4'b1110;
            key_code_q <= 4'h0;
            key_new_q  <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            div_cnt_q  <= div_cnt_d;
            db_cnt_q   <= db_cnt_d;
            col_out_q  <= col_out_d;
            key_code_q <= key_code_d;
            key_new_q  <= key_new_d;
            key_held_q <= key_held_d;
        end
    end

    // Register image for the load path.
    always_comb begin
        key_data               = 32'h0;
        key_data[3:0]          = key_code_q;
        key_data[KEY_NEW_BIT]  = key_new_q;
        key_data[KEY_HELD_BIT] = key_held_q;
    end

    assign col_out = col_out_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYC=8 and a
// behavioural keypad matrix that pulls rows low only while their column is driven.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_rd;
    logic [31:0] key_data;

    logic [3:0]  press_rows;
    logic [1:0]  press_col;
    logic        force_en;
    logic [3:0]  force_val;

    int errors = 0;
    int checks = 0;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_rd   (key_rd),
        .key_data (key_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: pressed switches connect their rows to the driven column.
    always_comb begin
        if (force_en) begin
            row_in = force_val;
        end else if (press_rows != 4'h0 && col_out[press_col] == 1'b0) begin
            row_in = ~press_rows;
        end else begin
            row_in = 4'hF;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] one_hot;
        logic [3:0] exp_col;
        rst_n      = 1'b0;
        key_rd     = 1'b0;
        press_rows = 4'h0;
        press_col  = 2'd0;
        force_en   = 1'b0;
        force_val  = 4'hF;
        one_hot    = 4'b0001;

        // Idle sweep: each column held for 4 cycles, no key reported.
        do_reset();
        check("reset_col", {28'h0, col_out}, 32'hE);
        check("reset_data", key_data, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_col = ~(one_hot << ((k / 4) % 4));
            check("sweep_col", {28'h0, col_out}, {28'h0, exp_col});
            check("sweep_data", key_data, 32'h0);
        end

        // Key '6' (row1, col2) held for 40 cycles.
        do_reset();
        press_rows = 4'b0010;
        press_col  = 2'd2;
        ticks(40);
        check("key6_data", key_data, 32'h36);
        check("key6_col", {28'h0, col_out}, 32'hB);

        // 3-cycle row0 glitch across the col0 sample.
        press_rows = 4'h0;
        do_reset();
        tick();
        force_val = 4'b1110;
        force_en  = 1'b1;
        ticks(3);
        force_en  = 1'b0;
        check("glitch_frozen", {28'h0, col_out}, 32'hE);
        ticks(3);
        check("glitch_col1", {28'h0, col_out}, 32'hD);
        ticks(3);
        check("glitch_col1_hold", {28'h0, col_out}, 32'hD);
        tick();
        check("glitch_col2", {28'h0, col_out}, 32'hB);
        check("glitch_data", key_data, 32'h0);

        // '#' (row3, col2): press, read-clear, release.
        do_reset();
        press_rows = 4'b1000;
        press_col  = 2'd2;
        ticks(19);
        check("hash_before_accept", key_data, 32'h0);
        tick();
        check("hash_accept", key_data, 32'h3F);
        key_rd = 1'b1;
        tick();
        key_rd = 1'b0;
        check("hash_read_clear", key_data, 32'h2F);
        press_rows = 4'h0;
        ticks(10);
        check("hash_release_pending", key_data, 32'h2F);
        tick();
        check("hash_released", key_data, 32'h0F);
        check("hash_col_advance", {28'h0, col_out}, 32'h7);

        // Ghosting: rows 0 and 2 low in col1 is ignored and scanning continues.
        press_rows = 4'b0101;
        press_col  = 2'd1;
        ticks(11);
        check("ghost_col1", {28'h0, col_out}, 32'hD);
        check("ghost_data_a", key_data, 32'h0F);
        tick();
        check("ghost_col2", {28'h0, col_out}, 32'hB);
        check("ghost_data_b", key_data, 32'h0F);

        // Key '1' with key_rd on the accepting edge, then async reset while held.
        press_rows = 4'b0001;
        press_col  = 2'd0;
        do_reset();
        ticks(11);
        check("rdset_before", key_data, 32'h0);
        key_rd = 1'b1;
        tick();
        key_rd = 1'b0;
        check("rdset_accept", key_data, 32'h31);
        tick();
        check("rdset_stable", key_data, 32'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", key_data, 32'h0);
        check("async_rst_col", {28'h0, col_out}, 32'hE);
        tick();
        rst_n = 1'b1;
        ticks(11);
        check("redebounce_before", key_data, 32'h0);
        tick();
        check("redebounce_accept", key_data, 32'h31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
